// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helpers for the serial BCD adder.
package bcd_pkg;

  localparam int DW = 4;
  localparam logic [DW-1:0] BCD_MAX = 4'd9;
  localparam logic [DW-1:0] BCD_ADJ = 4'd6;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic [DW-1:0] nines_comp(input logic [DW-1:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: digit + digit + carry -> digit + carry.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic          ci,
  output logic [DW-1:0] s,
  output logic          co
);

  logic [DW:0] raw;

  always_comb begin
    raw = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, ci};
    co  = (raw > {1'b0, BCD_MAX});
    // Adding 6 skips the six unused 4-bit codes; the carry is taken from co.
    s   = co ? (raw[DW-1:0] + BCD_ADJ) : raw[DW-1:0];
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD adder, one digit per clock through a shared digit adder.
// Optional macro BCD_SUB_EN adds op_sub for nine's-complement subtraction.
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic             cin,
`ifdef BCD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [4*NDIG-1:0] sum,
  output logic             cout,
  output logic             invalid
);

  localparam int W  = NDIG * DW;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d, cout_q, cout_d;
  logic          invalid_q, invalid_d, busy_q, busy_d, done_q, done_d;

  logic [DW-1:0] x_dig, y_dig, s_dig;
  logic          c_dig;
  logic          sub_sel, cin_eff, inv_in;
  logic [W-1:0]  b_eff;

`ifdef BCD_SUB_EN
  assign sub_sel = op_sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign x_dig = a_q[idx_q*DW +: DW];
  assign y_dig = b_q[idx_q*DW +: DW];

  bcd_digit_add u_dig (
    .x  (x_dig),
    .y  (y_dig),
    .ci (carry_q),
    .s  (s_dig),
    .co (c_dig)
  );

  // Validity is judged on the raw operands, before any complementing of b.
  always_comb begin
    inv_in  = 1'b0;
    b_eff   = b;
    cin_eff = sub_sel ? 1'b1 : cin;
    for (int i = 0; i < NDIG; i++) begin
      if (a[i*DW +: DW] > BCD_MAX || b[i*DW +: DW] > BCD_MAX) inv_in = 1'b1;
      if (sub_sel) b_eff[i*DW +: DW] = nines_comp(b[i*DW +: DW]);
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;
    busy_d    = (state_q == ST_RUN);
    done_d    = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b_eff;
          carry_d   = cin_eff;
          invalid_d = inv_in;
          sum_d     = '0;
          cout_d    = 1'b0;
          idx_d     = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*DW +: DW] = s_dig;
        carry_d = c_dig;
        if (idx_q == LAST) begin
          cout_d  = c_dig;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Scoreboard bench for bcd_serial_adder_ctrl (NDIG=4); covers BCD_SUB_EN when defined.
module tb_bcd_serial_adder_ctrl;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;
  localparam int MOD  = 10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef BCD_SUB_EN
  logic         op_sub = 1'b0;
`endif
  logic         busy, done, cout, invalid;
  logic [W-1:0] sum;

  bcd_serial_adder_ctrl #(.NDIG(NDIG)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
`ifdef BCD_SUB_EN
    .op_sub  (op_sub),
`endif
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;
    logic         chk_sum;
    int           k;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Completion monitor: every done must match the oldest outstanding request.
  exp_t m_e;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        m_e = sb.pop_front();
        if (m_e.chk_sum) begin
          chk("sum", 32'(sum), 32'(m_e.sum));
          chk("cout", 32'(cout), 32'(m_e.cout));
        end
        chk("invalid", 32'(invalid), 32'(m_e.invalid));
        chk("latency", 32'(cyc - m_e.k), 32'(NDIG + 1));
      end
    end
  end

  // Called at a negedge; leaves on the negedge where done is visible.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tcin, input logic tsub, input logic repulse);
    exp_t e;
    int   av, bv, r;
    logic inv = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (ta[i*4 +: 4] > 4'd9 || tb_v[i*4 +: 4] > 4'd9) inv = 1'b1;
    av = bcd2int(ta);
    bv = bcd2int(tb_v);
    if (tsub) begin
      r      = av - bv + MOD;
      e.cout = (av >= bv);
    end else begin
      r      = av + bv + int'(tcin);
      e.cout = (r >= MOD);
    end
    e.sum     = int2bcd(r % MOD);
    e.invalid = inv;
    e.chk_sum = !inv;
    e.k       = cyc + 1;
    a = ta; b = tb_v; cin = tcin;
`ifdef BCD_SUB_EN
    op_sub = tsub;
`endif
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    chk("busy_accept", 32'(busy), 32'd0);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 1; i <= NDIG + 1; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy_run", 32'(busy), 32'(i <= NDIG));
      if (repulse && i == 1) begin
        start = 1'b1;
        a = 16'h9999; b = 16'h9999;
      end
    end
    #1 chk("drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_invalid", 32'(invalid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NDIG; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(9));
        rb[i*4 +: 4] = 4'($urandom_range(9));
      end
      do_op(ra, rb, 1'($urandom), 1'b0, 1'b0);
    end

    // Abort two digits into an operation.
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("sum_mid", 32'(sum), 32'h0012);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_invalid", 32'(invalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    do_op(16'h0456, 16'h0544, 1'b0, 1'b0, 1'b0);

    do_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
    do_op(16'h5000, 16'h1234, 1'b0, 1'b1, 1'b0);
    do_op(16'h1234, 16'h5000, 1'b1, 1'b1, 1'b0);
    do_op(16'h0777, 16'h0777, 1'b0, 1'b1, 1'b0);
`endif

    repeat (6) @(negedge clk);
    chk("final_queue", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
